// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer in front of i2c_master. It turns one register read
// or write command into the master's byte-level en/din/stop handshake, checks
// the ACK after every written byte and enforces the bus-idle guard after STOP.
module i2c_reg_ctrl #(
  parameter int unsigned STOP_WAIT = 1100,
  parameter int unsigned TIMEOUT   = 16384
) (
  input  logic       clk,
  input  logic       rst,
  // command side
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  // response side
  output logic       rsp_valid,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  // i2c_master control
  output logic       m_en,
  output logic       m_stop,
  output logic [7:0] m_din,
  input  logic       m_busy,
  input  logic       m_ack,
  input  logic       m_valid,
  input  logic [7:0] m_dout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  typedef enum logic [3:0] {
    IDLE, START, WAIT_HI, WAIT_LO, ADDR_W, REG, WDATA, STOP,
    GUARD, RSTART, ADDR_R, RD_STOP, WAIT_VALID, WAIT_IDLE, RESP
  } state_t;

  state_t             state, state_nxt;
  state_t             ret, ret_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               nack, nack_nxt;
  logic               rw_q, rw_nxt;
  logic [6:0]         dev_q, dev_nxt;
  logic [7:0]         reg_q, reg_nxt;
  logic [7:0]         wdata_q, wdata_nxt;

  logic               cmd_ready_nxt;
  logic               rsp_valid_nxt;
  logic [1:0]         rsp_err_nxt;
  logic [7:0]         rsp_rdata_nxt;
  logic               m_en_nxt;
  logic               m_stop_nxt;
  logic [7:0]         m_din_nxt;

  logic               tout;
  logic               guard_done;
  logic               ack_chk;

  assign tout       = (cnt == CNT_W'(TIMEOUT - 1));
  assign guard_done = (cnt == CNT_W'(STOP_WAIT - 1));
  // The byte after a START is the address cycle's START itself; only real bytes carry an ACK.
  assign ack_chk    = (ret != ADDR_W) && (ret != ADDR_R);

  // State, latched command and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ret       <= IDLE;
      cnt       <= '0;
      nack      <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= ERR_OK;
      rsp_rdata <= '0;
      m_en      <= 1'b0;
      m_stop    <= 1'b0;
      m_din     <= '0;
    end else begin
      state     <= state_nxt;
      ret       <= ret_nxt;
      cnt       <= cnt_nxt;
      nack      <= nack_nxt;
      rw_q      <= rw_nxt;
      dev_q     <= dev_nxt;
      reg_q     <= reg_nxt;
      wdata_q   <= wdata_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      m_en      <= m_en_nxt;
      m_stop    <= m_stop_nxt;
      m_din     <= m_din_nxt;
    end
  end

  // Next-state sequencing; outputs are derived from the state being entered.
  always_comb begin
    state_nxt     = state;
    ret_nxt       = ret;
    nack_nxt      = nack;
    rw_nxt        = rw_q;
    dev_nxt       = dev_q;
    reg_nxt       = reg_q;
    wdata_nxt     = wdata_q;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    m_din_nxt     = m_din;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          rw_nxt    = cmd_rw;
          dev_nxt   = cmd_dev;
          reg_nxt   = cmd_reg;
          wdata_nxt = cmd_wdata;
          nack_nxt  = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        ret_nxt   = ADDR_W;
        state_nxt = WAIT_HI;
      end
      RSTART: begin
        ret_nxt   = ADDR_R;
        state_nxt = WAIT_HI;
      end
      ADDR_W: begin
        ret_nxt   = REG;
        state_nxt = WAIT_HI;
      end
      REG: begin
        ret_nxt   = rw_q ? STOP : WDATA;
        state_nxt = WAIT_HI;
      end
      WDATA: begin
        ret_nxt   = STOP;
        state_nxt = WAIT_HI;
      end
      ADDR_R: begin
        ret_nxt   = RD_STOP;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (m_busy) begin
          state_nxt = WAIT_LO;
        end else if (tout) begin
          rsp_err_nxt = ERR_TOUT;
          state_nxt   = RESP;
        end
      end
      WAIT_LO: begin
        if (!m_busy) begin
          if (ack_chk && m_ack) begin
            nack_nxt  = 1'b1;
            state_nxt = STOP;
          end else begin
            state_nxt = ret;
          end
        end else if (tout) begin
          rsp_err_nxt = ERR_TOUT;
          state_nxt   = RESP;
        end
      end
      STOP: begin
        state_nxt = GUARD;
      end
      GUARD: begin
        if (guard_done) begin
          if (nack) begin
            rsp_err_nxt = ERR_NACK;
            state_nxt   = RESP;
          end else if (rw_q) begin
            state_nxt = RSTART;
          end else begin
            rsp_err_nxt = ERR_OK;
            state_nxt   = RESP;
          end
        end
      end
      RD_STOP: begin
        state_nxt = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (m_valid) begin
          rsp_rdata_nxt = m_dout;
          state_nxt     = WAIT_IDLE;
        end else if (tout) begin
          rsp_err_nxt = ERR_TOUT;
          state_nxt   = RESP;
        end
      end
      WAIT_IDLE: begin
        if (!m_busy) begin
          rsp_err_nxt = ERR_OK;
          state_nxt   = RESP;
        end else if (tout) begin
          rsp_err_nxt = ERR_TOUT;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    case (state_nxt)
      ADDR_W:  m_din_nxt = {dev_q, 1'b0};
      REG:     m_din_nxt = reg_q;
      WDATA:   m_din_nxt = wdata_q;
      ADDR_R:  m_din_nxt = {dev_q, 1'b1};
      default: m_din_nxt = m_din;
    endcase

    m_en_nxt      = (state_nxt == START) || (state_nxt == RSTART) ||
                    (state_nxt == ADDR_W) || (state_nxt == REG) ||
                    (state_nxt == WDATA) || (state_nxt == ADDR_R);
    m_stop_nxt    = (state_nxt == STOP) || (state_nxt == RD_STOP);
    rsp_valid_nxt = (state_nxt == RESP);
    cmd_ready_nxt = (state_nxt == IDLE);

    // Shared guard/timeout counter restarts whenever the state changes.
    if ((state_nxt != state) || (state == IDLE)) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Register-access sequencer that sits in front of `i2c_master` and turns single register read or write commands into the byte-level `en`/`din`/`stop` handshake that the master expects. It runs each transaction to completion, checks ACK after every written byte and returns read data or an error code. It also enforces bus-idle guard time after STOP. It is the only driver of the master's control inputs in the design.

## Interface
- `STOP_WAIT`, 1100: cycles held after a write-side `m_stop` before the next START may be issued; must exceed the master's 1000-cycle STOP sequence.
- `TIMEOUT`, 16384: maximum cycles spent in any single wait state before abort.
- `clk` in 1: system clock, same clock as `i2c_master`.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high in IDLE only; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_rw` in 1: 0 = write, 1 = read.
- `cmd_dev` in 7: 7-bit device address.
- `cmd_reg` in 8: register address.
- `cmd_wdata` in 8: write data, ignored on reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 2: 00 = OK, 01 = NACK, 10 = timeout; valid with `rsp_valid`.
- `rsp_rdata` out 8: read data, valid with `rsp_valid` when `cmd_rw = 1` and `rsp_err = 00`; holds its value otherwise.
- `m_en`, `m_stop` out 1: one-cycle pulses to the master; never high in the same cycle.
- `m_din` out 8: byte to the master; stable from the `m_en` pulse until the next pulse.
- `m_busy`, `m_ack`, `m_valid` in 1: master status; `m_ack = 1` means NACK.
- `m_dout` in 8: master read byte.

## Operation
- On acceptance, `cmd_*` is latched; later changes on `cmd_*` are ignored.
- Byte step "SEND(b)":
  - Drive `m_din = b` and pulse `m_en`.
  - Wait for `m_busy = 1`, then for `m_busy = 0`.
  - After a data byte, sample `m_ack` in the cycle `m_busy` falls.
- Write sequence:
  - SEND_START: `m_en` pulse; `m_din` is don't-care.
  - SEND `{dev, 0}`, then SEND `reg`, then SEND `wdata`, checking ACK after each byte.
  - Pulse `m_stop`.
  - Hold in GUARD for `STOP_WAIT` cycles.
  - Respond OK.
- Read sequence:
  - SEND_START, SEND `{dev, 0}`, SEND `reg`, `m_stop`, GUARD. This first phase has no repeated START.
  - SEND_START, SEND `{dev, 1}`.
  - Pulse `m_stop` (not `m_en`), so the master reads one byte and returns NACK.
  - Wait for `m_valid`; latch `m_dout` into `rsp_rdata`.
  - Wait for `m_busy = 0` (master back in idle).
  - Respond OK.
- NACK on any written byte:
  - Pulse `m_stop`, then GUARD.
  - `rsp_valid` pulses with `rsp_err = 01`; no further bytes are sent.
- Timeout: if any wait state exceeds `TIMEOUT` cycles, `rsp_valid` pulses with `rsp_err = 10` and the block returns to IDLE. No `m_stop` is issued; system reset is required to recover the master.
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, ADDR_W, REG, WDATA, STOP, GUARD, RSTART, ADDR_R, RD_STOP, WAIT_VALID, WAIT_IDLE, RESP.
  - WAIT_HI/WAIT_LO are shared; a registered return-state field selects the successor.
- A phase counter of `TIMEOUT` width is reused for both guard and timeout counting, and clears on every state change.

## Timing
- Reset values:
  - `cmd_ready = 1`, state IDLE.
  - `rsp_valid = 0`, `rsp_err = 00`, `rsp_rdata = 00`.
  - `m_en = 0`, `m_stop = 0`, `m_din = 00`.
- All outputs are registered.
- Acceptance to first `m_en` pulse: 1 cycle. `cmd_ready` drops the cycle after acceptance and returns high in the cycle after `rsp_valid`.
- `m_busy` is registered in the master and rises 1 cycle after `m_en`. WAIT_HI must not check for a low `m_busy` before it has seen `m_busy = 1`.
- Controller overhead is ≤ 3 cycles per step.
- Nominal latency with the master's 500-cycle slots, ±3 per step:
  - Write: 1000 (START) + 3×4500 (bytes) + 1000 (STOP) + `STOP_WAIT`.
  - Read: write-phase cost minus one byte, plus 1000 + 4500 + 4500 + 1000 for the read phase.
- Reset asserted mid-transaction returns the block to IDLE immediately; no response is generated.

## Test plan
- Write to dev 0x50, reg 0x10, data 0xA5 with an ACKing slave model → bus bytes A0, 10, A5, then STOP; `rsp_err = 00`; `m_en` and `m_stop` never high together.
- Read from dev 0x50, reg 0x20 with the slave returning 0x3C → bytes A0, 20, STOP, START, A1; master NACKs the data byte; `rsp_rdata = 3C`, `rsp_err = 00`.
- Slave NACKs the address byte → no reg byte sent, `m_stop` pulsed, `rsp_err = 01`, `cmd_ready` returns high after GUARD.
- `m_busy` held at 0 by a stub after `m_en` → `rsp_valid` with `rsp_err = 10` exactly `TIMEOUT` cycles after the WAIT_HI entry.
- Back-to-back write commands → the second START `m_en` comes ≥ `STOP_WAIT` cycles after the first `m_stop`.
- `rst` pulsed mid-way through the second byte → all outputs at reset values asynchronously; `rsp_valid` stays 0; the next command completes normally.
